// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between four requesters, the arbiter, and the decoder/register file.
interface regfile_write_arbiter_if #(parameter int DATA_W = 8);
  logic                   clear_req;
  logic [3:0]             req_valid;
  logic [3:0][3:0]        req_addr;
  logic [3:0][DATA_W-1:0] req_data;
  logic [3:0]             req_ready;
  logic                   wr_en;
  logic [3:0]             wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [1:0]             wr_src;
  logic                   init_done;

  modport slave (
    input  clear_req, req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, wr_src, init_done
  );
  modport master (
    output clear_req, req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, wr_src, init_done
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among four requesters (round-robin) and
// zero-sweeps all 16 registers after reset or on clear_req.
module regfile_write_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  regfile_write_arbiter_if.slave   bus
);
  typedef enum logic {INIT, ARB} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        rr_q, rr_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_src_q, wr_src_d;
  logic              done_q, done_d;

  logic [3:0] gnt;
  logic       gnt_found;
  logic [1:0] gnt_id;
  logic [1:0] idx;

  // Round-robin search starting at rr_q; clear_req suppresses any grant.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    if (state_q == ARB && !bus.clear_req) begin
      for (int i = 0; i < 4; i++) begin
        idx = rr_q + 2'(i);
        if (!gnt_found && bus.req_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_id    = idx;
        end
      end
      if (gnt_found) gnt[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    done_d    = done_q;
    case (state_q)
      INIT: begin
        if (bus.clear_req) begin
          cnt_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = '0;
          wr_src_d  = '0;
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ARB;
            done_d  = 1'b1;
          end
        end
      end
      ARB: begin
        if (bus.clear_req) begin
          state_d = INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else if (gnt_found) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bus.req_addr[gnt_id];
          wr_data_d = bus.req_data[gnt_id];
          wr_src_d  = gnt_id;
          rr_d      = gnt_id + 2'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_src    = wr_src_q;
  assign bus.init_done = done_q;
endmodule
